cla32_adder: RTL and testbench
==============================

CLA32_ADDER -- requirements
Module: cla32_adder

Interface
REQ-001 The block SHALL have no parameters; the width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  operands on a, b, cin are valid this cycle.
REQ-005 a  input  32  operand A, unsigned.
REQ-006 b  input  32  operand B, unsigned.
REQ-007 cin  input  1  carry-in.
REQ-008 out_valid  output  1  registered results are valid.
REQ-009 sum  output  32  registered (a+b+cin) mod 2^32.
REQ-010 cout  output  1  registered carry-out of bit 31.
REQ-011 gp  output  1  registered 32-bit group propagate.
REQ-012 gg  output  1  registered 32-bit group generate.

Function
REQ-013 Per-bit signals SHALL be p_i = a_i XOR b_i and g_i = a_i AND b_i.
REQ-014 Carries SHALL use two-level lookahead:
- 4-bit blocks produce block P/G.
- A lookahead unit over the 8 blocks produces the block carry-ins.
- No ripple path SHALL span more than 4 bits.
REQ-015 gp SHALL equal the AND of all p_i; gg SHALL equal the lookahead group generate over bits 31..0.
REQ-016 cout SHALL equal gg OR (gp AND cin), and {cout,sum} SHALL equal a+b+cin as a 33-bit value.
REQ-017 Latency SHALL be exactly 1 cycle: a rising clk edge with in_valid=1 registers all results, and out_valid goes to 1 on that edge.
REQ-018 A rising clk edge with in_valid=0 SHALL clear out_valid to 0 and hold sum, cout, gp and gg unchanged.
REQ-019 Back-to-back in_valid SHALL be accepted every cycle; there is no backpressure.
REQ-020 Operands are unsigned; carry-out beyond bit 32 SHALL be discarded.

Reset
REQ-021 While rst=1, out_valid, sum, cout, gp, gg (and ovf when present) SHALL be 0 immediately, independent of clk.
REQ-022 A transaction in flight when rst asserts SHALL be dropped.
REQ-023 The first capture after reset SHALL happen on the first rising clk edge with rst=0 and in_valid=1.

Configuration
REQ-024 Macro CLA32_OVF_EN, when defined, SHALL add output ovf (1 bit, registered with sum) equal to c31 XOR cout, i.e. two's-complement signed overflow.
REQ-025 When CLA32_OVF_EN is undefined, port ovf and its logic SHALL NOT exist, and all other behaviour SHALL be unchanged.

Structure
REQ-026 Package cla32_pkg SHALL hold:
- WIDTH=32, BLK_W=4, NUM_BLK=8.
- typedef pg_t (struct of p, g).
REQ-027 Sub-module cla4_block SHALL implement one 4-bit lookahead block: inputs a[3:0], b[3:0], c_in; outputs s[3:0], P, G.
REQ-028 cla32_adder SHALL instantiate 8 cla4_block, the second-level lookahead logic, and the output register stage.

Verification
REQ-029 a=0xFFFFFFFF, b=0x00000001, cin=0 -> next cycle sum=0x00000000, cout=1, gp=0, gg=1, out_valid=1.
REQ-030 a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, gp=1, gg=0.
REQ-031 a=0x12345678, b=0x87654321, cin=0 -> sum=0x99999999, cout=0, gp=0, gg=0.
REQ-032 Overflow cases (ovf checked only with CLA32_OVF_EN):
- a=0x80000000, b=0x80000000, cin=1 -> sum=0x00000001, cout=1, ovf=1.
- a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-033 Apply 3 back-to-back valid operand sets, then rst=1 mid-cycle -> all outputs 0 before the next edge; after release, in_valid=0 keeps out_valid=0.
REQ-034 Randomized: 1000 random (a,b,cin) with random in_valid -> {cout,sum} equals the 33-bit a+b+cin one cycle later on every valid cycle.

Source files
------------

// File: rtl/cla32_pkg.sv
// Shared constants and types for the 32-bit two-level carry-lookahead adder.
//   WIDTH   : operand width
//   BLK_W   : width of one first-level lookahead block
//   NUM_BLK : number of first-level blocks
//   pg_t    : block propagate/generate pair
package cla32_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned BLK_W   = 4;
    localparam int unsigned NUM_BLK = WIDTH / BLK_W;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Carry out of a span of pg pairs [hi:lo]; a flat sum-of-products per span.
    function automatic logic span_carry(input pg_t pg[NUM_BLK], input int lo, input int hi,
                                        input logic c_lo);
        logic carry;
        logic prop;
        carry = 1'b0;
        prop  = 1'b1;
        for (int j = hi; j >= lo; j--) begin
            carry = carry | (prop & pg[j].g);
            prop  = prop & pg[j].p;
        end
        return carry | (prop & c_lo);
    endfunction

endpackage

// File: rtl/cla4_block.sv
// One 4-bit carry-lookahead block: internal carries are computed in flat
// lookahead form from c_in, never rippled bit to bit.
// Ports:
//   a, b : 4-bit operand slices
//   c_in : carry into bit 0 of the block
//   s    : 4-bit sum slice
//   P    : block propagate (all bits propagate)
//   G    : block generate (block produces a carry regardless of c_in)
module cla4_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       P,
    output logic       G
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Lookahead carries into each bit of the block.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;

    assign P = &p;
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla32_adder.sv
// 32-bit unsigned adder built from eight 4-bit lookahead blocks and a second
// lookahead level over the blocks, with a single registered output stage.
// Optional feature: define CLA32_OVF_EN to add the signed-overflow output ovf.
// Ports:
//   clk, rst  : rising-edge clock, asynchronous active-high reset
//   in_valid  : a, b, cin valid this cycle
//   a, b, cin : unsigned operands and carry-in
//   out_valid : registered results valid
//   sum, cout : registered (a+b+cin) and its carry-out
//   gp, gg    : registered 32-bit group propagate / generate
//   ovf       : registered two's-complement overflow (CLA32_OVF_EN only)
module cla32_adder
    import cla32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        out_valid,
    output logic [31:0] sum,
    output logic        cout,
    output logic        gp,
`ifdef CLA32_OVF_EN
    output logic        ovf,
`endif
    output logic        gg
);

    pg_t                blk_pg [NUM_BLK];
    logic [NUM_BLK-1:0] blk_c;
    logic [WIDTH-1:0]   sum_c;
    logic               gp_c;
    logic               gg_c;
    logic               cout_c;

    // First level: eight 4-bit lookahead blocks.
    for (genvar k = 0; k < int'(NUM_BLK); k++) begin : g_blk
        logic blk_p;
        logic blk_g;

        cla4_block u_blk (
            .a    (a[k*BLK_W +: BLK_W]),
            .b    (b[k*BLK_W +: BLK_W]),
            .c_in (blk_c[k]),
            .s    (sum_c[k*BLK_W +: BLK_W]),
            .P    (blk_p),
            .G    (blk_g)
        );

        assign blk_pg[k].p = blk_p;
        assign blk_pg[k].g = blk_g;
    end

    // Second level: each block carry-in is its own flat lookahead term.
    always_comb begin
        blk_c    = '0;
        blk_c[0] = cin;
        for (int k = 1; k < int'(NUM_BLK); k++) begin
            blk_c[k] = span_carry(blk_pg, 0, k - 1, cin);
        end
    end

    // Group terms over all 32 bits; gp is the AND of all block P, i.e. of all p_i.
    always_comb begin
        gp_c = 1'b1;
        for (int k = 0; k < int'(NUM_BLK); k++) begin
            gp_c = gp_c & blk_pg[k].p;
        end
        gg_c   = span_carry(blk_pg, 0, int'(NUM_BLK) - 1, 1'b0);
        cout_c = gg_c | (gp_c & cin);
    end

`ifdef CLA32_OVF_EN
    logic ovf_c;

    // Carry into bit 31 is recovered as sum[31] ^ p[31].
    assign ovf_c = (sum_c[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1]) ^ cout_c;
`endif

    // Output register stage: capture on in_valid, otherwise hold and drop out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            gp        <= 1'b0;
            gg        <= 1'b0;
`ifdef CLA32_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_c;
                cout <= cout_c;
                gp   <= gp_c;
                gg   <= gg_c;
`ifdef CLA32_OVF_EN
                ovf  <= ovf_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cla32_adder.sv
// Self-checking bench for cla32_adder: directed vectors, reset behaviour and
// randomized traffic checked against an arithmetic reference model.
module tb_cla32_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;
    logic        gp;
    logic        gg;
`ifdef CLA32_OVF_EN
    logic        ovf;
`endif

    int n_assert;
    int n_fail;

    // Reference model state (what the outputs should hold).
    logic        m_valid;
    logic [31:0] m_sum;
    logic        m_cout;
    logic        m_gp;
    logic        m_gg;
    logic        m_ovf;

    cla32_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .gp        (gp),
`ifdef CLA32_OVF_EN
        .ovf       (ovf),
`endif
        .gg        (gg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".sum"},       sum,            m_sum);
        check({tag, ".cout"},      32'(cout),      32'(m_cout));
        check({tag, ".gp"},        32'(gp),        32'(m_gp));
        check({tag, ".gg"},        32'(gg),        32'(m_gg));
`ifdef CLA32_OVF_EN
        check({tag, ".ovf"},       32'(ovf),       32'(m_ovf));
`endif
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        m_sum   = '0;
        m_cout  = 1'b0;
        m_gp    = 1'b0;
        m_gg    = 1'b0;
        m_ovf   = 1'b0;
    endtask

    // Reference: plain wide arithmetic, no lookahead structure.
    task automatic model_edge(input logic v, input logic [31:0] x, input logic [31:0] y,
                              input logic c);
        logic [32:0] full;
        logic [32:0] nocarry;
        m_valid = v;
        if (v) begin
            full    = 33'(x) + 33'(y) + 33'(c);
            nocarry = 33'(x) + 33'(y);
            m_sum   = full[31:0];
            m_cout  = full[32];
            m_gp    = ((x ^ y) == 32'hFFFF_FFFF);
            m_gg    = nocarry[32];
            m_ovf   = (x[31] == y[31]) && (full[31] != x[31]);
        end
    endtask

    // Drive one cycle of inputs, clock it, check outputs 1 time unit after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] x,
                        input logic [31:0] y, input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
        @(posedge clk);
        model_edge(v, x, y, c);
        #1;
        check_model(tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        model_clear();
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        // Reset state before any clock edge.
        #1;
        check_model("reset0");
        @(posedge clk);
        #1;
        check_model("reset_edge");
        rst = 1'b0;

        // Idle after reset keeps out_valid low.
        step("idle", 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b1);

        // Directed vectors with literal expectations as well as the model.
        step("max_plus1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        check("max_plus1.lit_sum", sum, 32'h0000_0000);
        check("max_plus1.lit_flags", {28'h0, out_valid, cout, gp, gg}, 32'hD);

        step("max_cin", 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        check("max_cin.lit_sum", sum, 32'h0000_0000);
        check("max_cin.lit_flags", {28'h0, out_valid, cout, gp, gg}, 32'hE);

        step("pattern", 1'b1, 32'h1234_5678, 32'h8765_4321, 1'b0);
        check("pattern.lit_sum", sum, 32'h9999_9999);
        check("pattern.lit_flags", {28'h0, out_valid, cout, gp, gg}, 32'h8);

        step("ovf_neg", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        check("ovf_neg.lit_sum", sum, 32'h0000_0001);
        check("ovf_neg.lit_cout", 32'(cout), 32'd1);

        step("ovf_pos", 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        check("ovf_pos.lit_sum", sum, 32'h8000_0000);
        check("ovf_pos.lit_cout", 32'(cout), 32'd0);

        // Invalid cycle clears out_valid and holds the previous results.
        step("hold", 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        check("hold.lit_sum", sum, 32'h8000_0000);

        // Three back-to-back transactions, then reset asserted mid-cycle.
        step("b2b0", 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        step("b2b1", 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1);
        step("b2b2", 1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
        in_valid = 1'b1;
        a        = 32'hCAFE_0000;
        b        = 32'h0000_BABE;
        #3;
        rst = 1'b1;
        model_clear();
        #1;
        check_model("rst_async");
        @(posedge clk);
        #1;
        check_model("rst_held");

        // Release mid-cycle with in_valid low: nothing may be captured.
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_model("post_rst_idle");

        // First capture after reset.
        step("post_rst_cap", 1'b1, 32'h0000_0002, 32'h0000_0003, 1'b1);

        // Randomized traffic with random in_valid.
        for (int i = 0; i < 1000; i++) begin
            logic        v;
            logic [31:0] x;
            logic [31:0] y;
            logic        c;
            v = 1'($urandom_range(0, 3) != 0);
            x = $urandom;
            y = $urandom;
            c = 1'($urandom_range(0, 1));
            // Bias some operands toward long carry chains.
            if ((i % 8) == 0) y = ~x;
            step("rand", v, x, y, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
